event_generator_unit_resource_handshake: RTL



---
 rtl/event_generator_unit_resource_handshake_pkg.sv | 22 ++
 rtl/event_generator_unit_resource_handshake_pair.sv | 108 ++++++++++
 rtl/event_generator_unit_resource_handshake.sv | 68 ++++++
 3 files changed

// File: rtl/event_generator_unit_resource_handshake_pkg.sv
// Shared types and constants for the event generator unit resource handshake.
package pa_EventGeneratorUnit;

  localparam int unsigned HOLD_CYCLES_DEFAULT    = 32'd4;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;

  // One-hot so req/ready decode stays a single flop per output.
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_REQ     = 5'b00010,
    ST_ACTIVE  = 5'b00100,
    ST_HOLD    = 5'b01000,
    ST_RELEASE = 5'b10000
  } hs_state_e;

  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned timeout);
    int unsigned m;
    m = (hold > timeout) ? hold : timeout;
    return (m < 32'd1) ? 32'd1 : $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/event_generator_unit_resource_handshake_pair.sv
// One clock-power pair: four-phase req/ack FSM with release hold-off and sticky ack timeout.
module event_generator_unit_resource_handshake_pair
  import pa_EventGeneratorUnit::*;
#(
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req_eff,
  input  logic i_ack_sync,
  input  logic i_err_clear,
  output logic o_req,
  output logic o_ready,
  output logic o_err
);

  localparam int unsigned    CW          = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  C_ONE       = CW'(1);
  localparam logic [CW-1:0]  C_TO_MAX    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  C_HOLD_LAST = CW'((HOLD_CYCLES > 32'd0) ? (HOLD_CYCLES - 32'd1) : 32'd0);
  localparam logic           C_NO_HOLD   = (HOLD_CYCLES == 32'd0);

  hs_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [CW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic          r_req, r_ready, r_err;
  logic          w_req_nxt, w_ready_nxt, w_err_nxt, w_to_set;

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_to_cnt   <= '0;
      r_req      <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_req      <= w_req_nxt;
      r_ready    <= w_ready_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (i_req_eff && !i_ack_sync) w_state_nxt = ST_REQ;     else w_state_nxt = ST_IDLE;
      ST_REQ:     if (i_ack_sync)               w_state_nxt = ST_ACTIVE;  else w_state_nxt = ST_REQ;
      ST_ACTIVE: begin
        if (i_req_eff)      w_state_nxt = ST_ACTIVE;
        else if (C_NO_HOLD) w_state_nxt = ST_RELEASE;
        else                w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_req_eff)                      w_state_nxt = ST_ACTIVE;
        else if (r_hold_cnt >= C_HOLD_LAST) w_state_nxt = ST_RELEASE;
        else                                w_state_nxt = ST_HOLD;
      end
      ST_RELEASE: if (!i_ack_sync) w_state_nxt = ST_IDLE; else w_state_nxt = ST_RELEASE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Saturating counters; both restart on any state change.
  always_comb begin
    w_hold_cnt_nxt = '0;
    w_to_cnt_nxt   = '0;
    if (w_state_nxt != r_state) begin
      w_hold_cnt_nxt = '0;
      w_to_cnt_nxt   = '0;
    end else begin
      if ((r_state == ST_HOLD) && (r_hold_cnt != '1)) w_hold_cnt_nxt = r_hold_cnt + C_ONE;
      else                                            w_hold_cnt_nxt = r_hold_cnt;
      if (((r_state == ST_REQ) || (r_state == ST_RELEASE)) && (r_to_cnt != C_TO_MAX))
        w_to_cnt_nxt = r_to_cnt + C_ONE;
      else
        w_to_cnt_nxt = r_to_cnt;
    end
  end

  assign w_to_set = (r_to_cnt != C_TO_MAX) && (w_to_cnt_nxt == C_TO_MAX);

  // Output decode from the next state so the outputs come straight from flops.
  always_comb begin
    w_req_nxt   = 1'b0;
    w_ready_nxt = 1'b0;
    case (w_state_nxt)
      ST_REQ:    begin w_req_nxt = 1'b1; w_ready_nxt = 1'b0; end
      ST_ACTIVE: begin w_req_nxt = 1'b1; w_ready_nxt = 1'b1; end
      ST_HOLD:   begin w_req_nxt = 1'b1; w_ready_nxt = 1'b1; end
      default:   begin w_req_nxt = 1'b0; w_ready_nxt = 1'b0; end
    endcase
    if (w_to_set)         w_err_nxt = 1'b1;
    else if (i_err_clear) w_err_nxt = 1'b0;
    else                  w_err_nxt = r_err;
  end

  assign o_req   = r_req;
  assign o_ready = r_ready;
  assign o_err   = r_err;

endmodule

// File: rtl/event_generator_unit_resource_handshake.sv
// PCGC resource handshake: synchronises async request/ack and runs one handshake channel per pair.
module event_generator_unit_resource_handshake
  import pa_EventGeneratorUnit::*;
#(
  parameter int unsigned INCLUDE_EVENT_GENERATOR_UNIT = 32'd1,
  parameter int unsigned NUM_CLOCK_POWER_PAIR         = 32'd2,
  parameter int unsigned HOLD_CYCLES                  = HOLD_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES               = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CLOCK_POWER_PAIR-1:0] reqResources,
  input  logic [NUM_CLOCK_POWER_PAIR-1:0] reqResources_a,
  input  logic [NUM_CLOCK_POWER_PAIR-1:0] pcgcAck,
  input  logic                            errClear,
  output logic [NUM_CLOCK_POWER_PAIR-1:0] pcgcReq,
  output logic [NUM_CLOCK_POWER_PAIR-1:0] resourceReady,
  output logic [NUM_CLOCK_POWER_PAIR-1:0] ackTimeoutErr
);

  generate
    if (INCLUDE_EVENT_GENERATOR_UNIT != 32'd0) begin : g_inc
      logic [NUM_CLOCK_POWER_PAIR-1:0] r_req_a_meta, r_req_a_sync;
      logic [NUM_CLOCK_POWER_PAIR-1:0] r_ack_meta, r_ack_sync;
      logic [NUM_CLOCK_POWER_PAIR-1:0] w_req_eff;

      // Two-flop synchronisers for the asynchronous request and ack inputs.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_req_a_meta <= '0;
          r_req_a_sync <= '0;
          r_ack_meta   <= '0;
          r_ack_sync   <= '0;
        end else begin
          r_req_a_meta <= reqResources_a;
          r_req_a_sync <= r_req_a_meta;
          r_ack_meta   <= pcgcAck;
          r_ack_sync   <= r_ack_meta;
        end
      end

      assign w_req_eff = reqResources | r_req_a_sync;

      for (genvar i = 0; i < NUM_CLOCK_POWER_PAIR; i++) begin : g_pair
        event_generator_unit_resource_handshake_pair #(
          .HOLD_CYCLES   (HOLD_CYCLES),
          .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_pair (
          .clk        (clk),
          .reset      (reset),
          .i_req_eff  (w_req_eff[i]),
          .i_ack_sync (r_ack_sync[i]),
          .i_err_clear(errClear),
          .o_req      (pcgcReq[i]),
          .o_ready    (resourceReady[i]),
          .o_err      (ackTimeoutErr[i])
        );
      end
    end else begin : g_none
      logic w_unused;
      assign w_unused      = ^{clk, reset, reqResources, reqResources_a, pcgcAck, errClear};
      assign pcgcReq       = '0;
      assign resourceReady = '0;
      assign ackTimeoutErr = '0;
    end
  endgenerate

endmodule
